// File: rtl/anfsqrt_seq.sv
// Sequential integer square root: digit recurrence, ITERS_PER_CYCLE iterations per clock.
// Optional ANFSQRT_SEQ_EARLY_START_EN skips leading zero bit-pairs of the operand.
module anfsqrt_seq #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned ITERS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_n,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH/2-1:0]     out_root,
  output logic [WIDTH/2:0]       out_rem,
  output logic                   busy
);

  localparam int unsigned RW   = WIDTH / 2;
  localparam int unsigned NCYC = RW / ITERS_PER_CYCLE;
  localparam int unsigned CW   = $clog2(NCYC + 1);

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("anfsqrt_seq: WIDTH must be even and >= 4");
  end
  if (ITERS_PER_CYCLE == 0 || (RW % ITERS_PER_CYCLE) != 0) begin : g_bad_ipc
    $error("anfsqrt_seq: ITERS_PER_CYCLE must divide WIDTH/2");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   att_q, att_d;
  logic [WIDTH-1:0] eps_q, eps_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    root_q, root_d;
  logic [RW:0]      rem_q, rem_d;

  logic [WIDTH:0]   att_init;
  logic [CW-1:0]    cnt_init;

`ifdef ANFSQRT_SEQ_EARLY_START_EN
  int unsigned msb;
  int unsigned pairs;
  int unsigned cyc;

  // Start count is rounded up to whole cycles; att is placed so that exactly
  // cnt*ITERS_PER_CYCLE iterations remain, which still only skips zero pairs.
  always_comb begin
    msb = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (in_n[i]) msb = i;
    end
    pairs    = msb / 2 + 1;
    cyc      = (pairs + ITERS_PER_CYCLE - 1) / ITERS_PER_CYCLE;
    cnt_init = CW'(cyc);
    att_init = (WIDTH + 1)'(1) << (2 * cyc * ITERS_PER_CYCLE);
  end
`else
  assign cnt_init = CW'(NCYC);
  assign att_init = {1'b1, {WIDTH{1'b0}}};
`endif

  // Unrolled iteration chain.
  logic [WIDTH:0]   att_nx;
  logic [WIDTH-1:0] eps_nx;
  logic [WIDTH-1:0] res_nx;
  logic [WIDTH:0]   delta;

  always_comb begin
    att_nx = att_q;
    eps_nx = eps_q;
    res_nx = res_q;
    delta  = '0;
    for (int i = 0; i < int'(ITERS_PER_CYCLE); i++) begin
      att_nx = att_nx >> 2;
      delta  = {1'b0, res_nx} + att_nx;
      if ({1'b0, eps_nx} >= delta) begin
        // delta <= eps < 2^WIDTH here, so the truncations are exact
        eps_nx = eps_nx - delta[WIDTH-1:0];
        res_nx = (res_nx >> 1) + att_nx[WIDTH-1:0];
      end else begin
        res_nx = res_nx >> 1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    att_d   = att_q;
    eps_d   = eps_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          eps_d   = in_n;
          res_d   = '0;
          att_d   = att_init;
          cnt_d   = cnt_init;
          state_d = StRun;
        end
      end
      StRun: begin
        att_d = att_nx;
        eps_d = eps_nx;
        res_d = res_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          root_d  = res_nx[RW-1:0];
          rem_d   = eps_nx[RW:0];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      att_q   <= '0;
      eps_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      att_q   <= att_d;
      eps_q   <= eps_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_root  = root_q;
  assign out_rem   = rem_q;

endmodule

// File: tb/tb_anfsqrt_seq.sv
// Directed + random bench for anfsqrt_seq: one instance with 1 and one with 4 iterations/cycle.
module tb_anfsqrt_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_n     [2];
  logic [15:0] out_root [2];
  logic [16:0] out_rem  [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  anfsqrt_seq #(.WIDTH(32), .ITERS_PER_CYCLE(1)) u_ipc1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_n(in_n[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_root(out_root[0]), .out_rem(out_rem[0]), .busy(busy[0])
  );

  anfsqrt_seq #(.WIDTH(32), .ITERS_PER_CYCLE(4)) u_ipc4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_n(in_n[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_root(out_root[1]), .out_rem(out_rem[1]), .busy(busy[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference root by binary search on r*r <= n.
  function automatic longint isqrt(input longint n);
    longint lo = 0, hi = 65535, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= n) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic int exp_lat(input int sel, input logic [31:0] n);
    int ipc = (sel == 0) ? 1 : 4;
`ifdef ANFSQRT_SEQ_EARLY_START_EN
    int msb = 0;
    for (int i = 0; i < 32; i++) if (n[i]) msb = i;
    return (msb / 2 + 1 + ipc - 1) / ipc;
`else
    return 16 / ipc;
`endif
  endfunction

  task automatic start_op(input int sel, input logic [31:0] n);
    int k = 0;
    @(negedge clk);
    while (!in_ready[sel] && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready[sel]) check_eq("ready_timeout", 64'(in_ready[sel]), 64'd1);
    in_valid[sel] = 1'b1;
    in_n[sel]     = n;
    @(posedge clk);
    #1;
    in_valid[sel] = 1'b0;
    in_n[sel]     = ~n;  // later changes must not matter
  endtask

  task automatic wait_done(input int sel, output int lat);
    bit got = 0;
    lat = 0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid[sel]) got = 1;
    end
    if (!got) check_eq("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_check(input string tag, input int sel, input logic [31:0] n,
                           input logic [15:0] er, input logic [16:0] em);
    int lat;
    start_op(sel, n);
    wait_done(sel, lat);
    check_eq({tag, "_root"}, 64'(out_root[sel]), 64'(er));
    check_eq({tag, "_rem"}, 64'(out_rem[sel]), 64'(em));
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat(sel, n)));
  endtask

  logic [31:0] vec_n    [6] = '{32'd99, 32'hFFFF_FFFF, 32'd1000000, 32'd0, 32'h4000_0000, 32'd144};
  logic [15:0] vec_root [6] = '{16'd9, 16'hFFFF, 16'd1000, 16'd0, 16'd32768, 16'd12};
  logic [16:0] vec_rem  [6] = '{17'd18, 17'h1FFFE, 17'd0, 17'd0, 17'd0, 17'd0};

  initial begin
    logic [15:0] hold_root;
    logic [16:0] hold_rem;
    logic [31:0] rn;
    longint      rr;
    int          lat, cyc, accepts, t0, t1, rises;

    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 2'b11;
    in_n[0]   = '0;
    in_n[1]   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("rst_in_ready", 64'(in_ready), 64'b11);
    check_eq("rst_out_valid", 64'(out_valid), 64'b00);
    check_eq("rst_busy", 64'(busy), 64'b00);
    check_eq("rst_root", 64'(out_root[0]), 64'd0);
    check_eq("rst_rem", 64'(out_rem[0]), 64'd0);

    // Directed vectors on both instances.
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 6; v++) begin
        run_check($sformatf("dir_s%0d_v%0d", s, v), s, vec_n[v], vec_root[v], vec_rem[v]);
      end
    end

    // Back-to-back issue on the 4-iteration instance.
    @(negedge clk);
    while (busy[1]) @(negedge clk);
    in_valid[1] = 1'b1;
    in_n[1]     = 32'h4000_0000;
    accepts = 0; cyc = 0; t0 = 0; t1 = 0;
    while (accepts < 2 && cyc < 50) begin
      @(negedge clk);
      if (in_ready[1]) begin
        if (accepts == 0) t0 = cyc;
        else t1 = cyc;
        accepts++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid[1] = 1'b0;
    check_eq("issue_accepts", 64'(accepts), 64'd2);
    check_eq("issue_interval", 64'(t1 - t0), 64'(exp_lat(1, 32'h4000_0000) + 2));
    wait_done(1, lat);
    check_eq("issue_root", 64'(out_root[1]), 64'd32768);

    // Back-pressure: result held, inputs ignored.
    out_ready[0] = 1'b0;
    start_op(0, 32'd1000000);
    wait_done(0, lat);
    hold_root = out_root[0];
    hold_rem  = out_rem[0];
    check_eq("bp_root", 64'(hold_root), 64'd1000);
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = i[0];
      in_n[0]     = 32'd49 + 32'(i);
      @(posedge clk);
      #1;
      check_eq("bp_hold_root", 64'(out_root[0]), 64'(hold_root));
      check_eq("bp_hold_rem", 64'(out_rem[0]), 64'(hold_rem));
      check_eq("bp_in_ready", 64'(in_ready[0]), 64'd0);
      check_eq("bp_out_valid", 64'(out_valid[0]), 64'd1);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_release_valid", 64'(out_valid[0]), 64'd0);
    check_eq("bp_release_ready", 64'(in_ready[0]), 64'd1);
    check_eq("bp_release_busy", 64'(busy[0]), 64'd0);

    // Reset in the middle of a run.
    start_op(0, 32'd99);
    rises = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid[0]) rises++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("mid_rst_in_ready", 64'(in_ready[0]), 64'd1);
    check_eq("mid_rst_busy", 64'(busy[0]), 64'd0);
    check_eq("mid_rst_root", 64'(out_root[0]), 64'd0);
    check_eq("mid_rst_rem", 64'(out_rem[0]), 64'd0);
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid[0]) rises++;
    end
    check_eq("mid_rst_no_out", 64'(rises), 64'd0);
    run_check("after_rst", 0, 32'd144, 16'd12, 17'd0);

    // Random operands against the reference model.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 100; i++) begin
        rn = $urandom >> $urandom_range(0, 31);
        rr = isqrt(longint'(rn));
        run_check($sformatf("rnd_s%0d_%0d", s, i), s, rn, 16'(rr),
                  17'(longint'(rn) - rr * rr));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
